// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The master is the upstream word source; the slave is the serializer itself.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             bit_en;
   logic             bit_d;
   logic             busy;
   logic             frame_done;

   modport master (
      output in_valid, in_data,
      input  in_ready, bit_en, bit_d, busy, frame_done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, bit_en, bit_d, busy, frame_done
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes WIDTH-bit words on a valid/ready handshake and
// emits them one bit per DIV clocks as a bit_d/bit_en strobe pair for the capture register.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int DIV       = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   bit_serializer_if.slave bus
);
   localparam int DIV_W = $clog2((DIV < 2) ? 2 : DIV);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   shift_q, shift_n;
   logic [IDX_W-1:0]   bit_idx, bit_idx_n;
   logic [DIV_W-1:0]   div_cnt, div_cnt_n;
   logic               bit_en_q, bit_en_n;
   logic               bit_d_q, bit_d_n;
   logic               done_q, done_n;
   logic               take;
   logic               emit_bit;

   // Ready also in the frame_done cycle so a waiting word can follow without a gap.
   assign bus.in_ready   = (state == IDLE) | done_q;
   assign bus.busy       = (state == SHIFT);
   assign bus.bit_en     = bit_en_q;
   assign bus.bit_d      = bit_d_q;
   assign bus.frame_done = done_q;

   assign take     = bus.in_valid & bus.in_ready;
   assign emit_bit = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_n   = state;
      shift_n   = shift_q;
      bit_idx_n = bit_idx;
      div_cnt_n = div_cnt;
      bit_en_n  = 1'b0;
      bit_d_n   = bit_d_q;
      done_n    = 1'b0;

      if (take) begin
         shift_n   = bus.in_data;
         bit_idx_n = '0;
         div_cnt_n = '0;
         state_n   = SHIFT;
      end else if (state == SHIFT) begin
         // The frame_done cycle belongs to the finished frame; without a new word, stop here.
         if (done_q) begin
            state_n = IDLE;
         end else if (div_cnt == DIV_LAST) begin
            bit_en_n  = 1'b1;
            bit_d_n   = emit_bit;
            shift_n   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
            div_cnt_n = '0;
            if (bit_idx == IDX_LAST) begin
               done_n    = 1'b1;
               bit_idx_n = '0;
            end else begin
               bit_idx_n = bit_idx + IDX_W'(1);
            end
         end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shift_q  <= '0;
         bit_idx  <= '0;
         div_cnt  <= '0;
         bit_en_q <= 1'b0;
         bit_d_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         shift_q  <= shift_n;
         bit_idx  <= bit_idx_n;
         div_cnt  <= div_cnt_n;
         bit_en_q <= bit_en_n;
         bit_d_q  <= bit_d_n;
         done_q   <= done_n;
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: two instances (DIV=1 MSB-first, DIV=4 LSB-first)
// driven with random and directed words and compared every cycle against a timing-rule model.
module tb_bit_serializer;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   bit_serializer_if #(.WIDTH(W)) bus0 ();
   bit_serializer_if #(.WIDTH(W)) bus1 ();

   bit_serializer #(.WIDTH(W), .DIV(1), .LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   bit_serializer #(.WIDTH(W), .DIV(4), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic         drv_valid [2];
   logic [W-1:0] drv_data  [2];
   logic ob_ready [2];
   logic ob_en    [2];
   logic ob_d     [2];
   logic ob_busy  [2];
   logic ob_done  [2];

   assign bus0.in_valid = drv_valid[0];
   assign bus0.in_data  = drv_data[0];
   assign bus1.in_valid = drv_valid[1];
   assign bus1.in_data  = drv_data[1];
   assign ob_ready[0] = bus0.in_ready;
   assign ob_ready[1] = bus1.in_ready;
   assign ob_en[0]    = bus0.bit_en;
   assign ob_en[1]    = bus1.bit_en;
   assign ob_d[0]     = bus0.bit_d;
   assign ob_d[1]     = bus1.bit_d;
   assign ob_busy[0]  = bus0.busy;
   assign ob_busy[1]  = bus1.busy;
   assign ob_done[0]  = bus0.frame_done;
   assign ob_done[1]  = bus1.frame_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic bit lsb_of(input int i);
      return i != 0;
   endfunction

   // Reference model: a frame accepted at the end of cycle a_c strobes bit k in cycle
   // a_c + 1 + DIV*(k+1) and ends (frame_done) at e_c = a_c + 1 + DIV*W.
   int           a_c [2];
   int           e_c [2];
   logic [W-1:0] cur_w [2];
   logic         exp_d [2];
   bit           xfer [2];
   logic [W-1:0] rx [2];
   int           rx_n [2];
   bit           busy_e, done_e, ready_e, en_e;
   int           off, k;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            a_c[i]   = -1000;
            e_c[i]   = -1000;
            exp_d[i] = 1'b0;
            rx_n[i]  = 0;
         end
         busy_e  = (cyc > a_c[i]) && (cyc <= e_c[i]);
         done_e  = (cyc == e_c[i]);
         ready_e = !busy_e || done_e;
         off     = cyc - a_c[i] - 1;
         en_e    = busy_e && (off > 0) && ((off % div_of(i)) == 0);
         if (en_e) begin
            k        = off / div_of(i) - 1;
            exp_d[i] = lsb_of(i) ? cur_w[i][k] : cur_w[i][W-1-k];
         end
         check($sformatf("d%0d_in_ready@%0d", i, cyc),   ob_ready[i], ready_e);
         check($sformatf("d%0d_busy@%0d", i, cyc),       ob_busy[i],  busy_e);
         check($sformatf("d%0d_bit_en@%0d", i, cyc),     ob_en[i],    en_e);
         check($sformatf("d%0d_frame_done@%0d", i, cyc), ob_done[i],  done_e);
         check($sformatf("d%0d_bit_d@%0d", i, cyc),      ob_d[i],     exp_d[i]);

         // Independent end-to-end view: reassemble the word from the observed strobes.
         if (ob_en[i]) begin
            rx[i] = lsb_of(i) ? {ob_d[i], rx[i][W-1:1]} : {rx[i][W-2:0], ob_d[i]};
            rx_n[i]++;
         end
         if (ob_done[i]) begin
            check($sformatf("d%0d_frame_bits@%0d", i, cyc), rx_n[i], W);
            check($sformatf("d%0d_frame_word@%0d", i, cyc), rx[i], cur_w[i]);
            rx_n[i] = 0;
         end

         xfer[i] = rst_n && drv_valid[i] && ready_e;
         if (xfer[i]) begin
            a_c[i]   = cyc;
            e_c[i]   = cyc + 1 + div_of(i) * W;
            cur_w[i] = drv_data[i];
            rx_n[i]  = 0;
         end
      end
   end

   // Send nwords to instance i; w0/w1 select the first two words (-1 = random).
   // b2b keeps in_valid high between words; wiggle changes in_data every stalled cycle.
   task automatic drive(input int i, input int nwords, input bit b2b, input bit wiggle,
                        input int w0, input int w1);
      logic [W-1:0] w;
      int budget;
      for (int n = 0; n < nwords; n++) begin
         if (n == 0 && w0 >= 0)      w = W'(w0);
         else if (n == 1 && w1 >= 0) w = W'(w1);
         else                        w = W'($urandom);
         if (!b2b) begin
            drv_valid[i] = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         drv_valid[i] = 1'b1;
         drv_data[i]  = w;
         budget = 0;
         do begin
            @(posedge clk);
            #1;
            budget++;
            if (!xfer[i] && wiggle) drv_data[i] = W'($urandom);
         end while (!xfer[i] && budget < 200);
         check($sformatf("d%0d_xfer_wait", i), xfer[i], 1'b1);
      end
      drv_valid[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((ob_busy[0] || ob_busy[1]) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_wait", {ob_busy[0], ob_busy[1]}, 2'b00);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      drv_valid[0] = 1'b0;
      drv_valid[1] = 1'b0;
      drv_data[0]  = '0;
      drv_data[1]  = '0;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      fork
         drive(0, 1, 1'b0, 1'b0, 'hA5, -1);
         drive(1, 1, 1'b0, 1'b0, 'h01, -1);
      join
      wait_idle();

      fork
         drive(0, 2, 1'b1, 1'b0, 'hFF, 'h00);
         drive(1, 2, 1'b1, 1'b0, 'hFF, 'h00);
      join
      wait_idle();

      fork
         drive(0, 3, 1'b1, 1'b1, 'h3C, -1);
         drive(1, 3, 1'b1, 1'b1, 'h3C, -1);
      join
      wait_idle();

      // Abort a frame while bit 3 of 8'hF0 is being strobed.
      drive(0, 1, 1'b0, 1'b0, 'hF0, -1);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy",       ob_busy[0],  1'b0);
      check("async_in_ready",   ob_ready[0], 1'b1);
      check("async_bit_en",     ob_en[0],    1'b0);
      check("async_bit_d",      ob_d[0],     1'b0);
      check("async_frame_done", ob_done[0],  1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      drive(0, 1, 1'b0, 1'b0, 'h96, -1);
      wait_idle();

      for (int r = 0; r < 4; r++) begin
         fork
            drive(0, 12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
            drive(1, 6,  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
         join
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
